// File: rtl/mux_nch_scan.sv
// N-channel W-bit mux, manual select or round-robin scan, channel-tagged registered output.
// Latency: 1 cycle from in_data/in_valid to out_data/out_ch/out_valid.
// Backpressure: out_ready=0 with a word held freezes the output stage, dwell counter and scan channel.
module mux_nch_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    input  logic                   sel_load,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic ST_MAN  = 1'b0;
    localparam logic ST_SCAN = 1'b1;

    localparam logic [SELW:0]   NCH_L   = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
    localparam logic [CW-1:0]   LAST_DW = CW'(DWELL - 1);

    logic            state;
    logic [SELW-1:0] cur_ch;
    logic [CW-1:0]   dwell_cnt;
    logic            load_en;
    logic [WIDTH-1:0] sel_data;
    logic            sel_vld;

    assign load_en = !out_valid || out_ready;

    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (cur_ch == SELW'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_vld  = in_valid[k];
            end
        end
    end

    // A mode transition takes priority over both sel_load and a dwell wrap on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_MAN;
            cur_ch    <= '0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                ST_MAN: begin
                    if (mode) begin
                        state     <= ST_SCAN;
                        dwell_cnt <= '0;
                    end else if (sel_load && ({1'b0, sel} < NCH_L)) begin
                        cur_ch <= sel;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        state     <= ST_MAN;
                        dwell_cnt <= '0;
                    end else if (load_en) begin
                        if (dwell_cnt == LAST_DW) begin
                            dwell_cnt <= '0;
                            cur_ch    <= (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_MAN;
                    dwell_cnt <= '0;
                end
            endcase
        end
    end

    // out_data keeps its last value on an empty load; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else if (load_en) begin
            if (sel_vld) begin
                out_data  <= sel_data;
                out_ch    <= cur_ch;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nch_scan.sv
// Directed bench for mux_nch_scan: manual select, invalid select, scan sequence, stall, reset.
module tb_mux_nch_scan;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 3;
    localparam int DWELL = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic                 sel_load;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] chval [NCH];

    mux_nch_scan #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .mode(mode), .sel(sel), .sel_load(sel_load),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [7:0] d, input logic [2:0] c);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_ch"}, 32'(out_ch), 32'(c));
    endtask

    task automatic drive_data();
        for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = chval[k];
    endtask

    initial begin
        chval[0] = 8'h10; chval[1] = 8'h3C; chval[2] = 8'hA5; chval[3] = 8'h7E;
        drive_data();
        rst = 1'b1; mode = 1'b0; sel = '0; sel_load = 1'b0;
        in_valid = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);

        // Manual select of ch2: the load edge still uses the old channel 0.
        sel = 3'd2; sel_load = 1'b1; in_valid = 4'hF;
        tick();
        sel_load = 1'b0;
        chk_word("man_old", 8'h10, 3'd0);
        tick();
        chk_word("man_ch2", 8'hA5, 3'd2);

        // Out-of-range select is ignored.
        sel = 3'd5; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        tick();
        chk_word("sel_oor", 8'hA5, 3'd2);

        // Manual ch1 with its valid low, then raised.
        sel = 3'd1; sel_load = 1'b1;
        tick();
        sel_load = 1'b0; in_valid = 4'b1101;
        tick();
        chk("gap_valid", 32'(out_valid), 32'd0);
        in_valid = 4'hF;
        tick();
        chk_word("gap_resume", 8'h3C, 3'd1);

        // Back to ch0, then enter scan; the transition edge itself loads ch0.
        sel = 3'd0; sel_load = 1'b1;
        tick();
        sel_load = 1'b0; mode = 1'b1;
        tick();
        chk_word("scan_entry", 8'h10, 3'd0);
        for (int i = 0; i < 17; i++) begin
            tick();
            chk_word("scan_seq", chval[(i / DWELL) % NCH], 3'((i / DWELL) % NCH));
        end

        // Scan position now ch0 with dwell 1: three more ch0 words, then ch1.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_word("scan_pre", 8'h10, 3'd0);
        end
        tick();
        chk_word("stall_word", 8'h3C, 3'd1);

        // Stall for 5 cycles; changing ch1 input must not leak into the held word.
        out_ready = 1'b0;
        chval[1] = 8'h99;
        drive_data();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_word("stall_hold", 8'h3C, 3'd1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_word("stall_resume", 8'h99, 3'd1);
        end
        tick();
        chk_word("stall_adv", 8'hA5, 3'd2);

        // Reset while a word is held in scan mode.
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b0; sel = 3'd3; sel_load = 1'b1;
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_ch", 32'(out_ch), 32'd0);
        chk("rst2_data", 32'(out_data), 32'd0);
        tick();
        sel_load = 1'b0;
        chk_word("rst2_ch0", 8'h10, 3'd0);
        tick();
        chk_word("rst2_man", 8'h7E, 3'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
